mmio_bridge: RTL and testbench

- Parametrised memory-mapped I/O bridge between the CPU data port and N_CH peripheral channels (LED, segment display, switch/button, UART, ...).
- Replaces the fixed single-cycle LED/switch decode with an address-decoded request/ready handshake, wait-state support, registered read return and error responses.
- Sits between the core's load/store path and the peripheral blocks; the core stalls on cpu_ready.

---
 rtl/mmio_pkg.sv | 13 +
 rtl/mmio_decode.sv | 21 ++
 rtl/mmio_bridge.sv | 94 +++++++++
 tb/tb_mmio_bridge.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: shared FSM state codes, default I/O window base, channel indices and timeout read value
package mmio_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t RESP = 2'd2;
  localparam logic [31:0] BASE_ADDR_DEF = 32'hFFFF_FC00;
  localparam int CH_LED = 0;
  localparam int CH_SEG = 1;
  localparam int CH_SW = 2;
  localparam int CH_UART = 3;
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mmio_decode.sv
// mmio_decode: combinational I/O window decode; addr -> in_range, channel idx, word offset ch_off
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int N_CH = 4,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int CH_SPAN_LOG2 = 4
) (
  input  logic [31:0]             addr,
  output logic                    in_range,
  output logic [3:0]              idx,
  output logic [CH_SPAN_LOG2-3:0] ch_off
);
  logic [32:0] a, lo, hi;
  assign a = {1'b0, addr};
  assign lo = {1'b0, BASE_ADDR};
  assign hi = lo + (33'(N_CH) << CH_SPAN_LOG2);
  assign in_range = (a >= lo) && (a < hi);
  assign idx = 4'((addr - BASE_ADDR) >> CH_SPAN_LOG2);
  assign ch_off = addr[CH_SPAN_LOG2-1:2];
endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: CPU load/store port to N_CH peripheral channels with req/ready handshake, wait states, error responses; define MMIO_TIMEOUT_EN to abort hung channels
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_CH = 4,
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int CH_SPAN_LOG2 = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [3:0]               cpu_be,
  input  logic [DATA_W-1:0]        cpu_wdata,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ready,
  output logic                     cpu_err,
  output logic [N_CH-1:0]          ch_sel,
  output logic                     ch_we,
  output logic [CH_SPAN_LOG2-3:0]  ch_off,
  output logic [3:0]               ch_be,
  output logic [DATA_W-1:0]        ch_wdata,
  input  logic [N_CH*DATA_W-1:0]   ch_rdata,
  input  logic [N_CH-1:0]          ch_ready
);
  state_t state;
  logic in_range, hit, expired;
  logic [3:0] idx;
  logic [CH_SPAN_LOG2-3:0] off;
  logic [DATA_W-1:0] sel_rdata;
  mmio_decode #(.N_CH(N_CH), .BASE_ADDR(BASE_ADDR), .CH_SPAN_LOG2(CH_SPAN_LOG2)) u_decode (
    .addr(cpu_addr), .in_range(in_range), .idx(idx), .ch_off(off)
  );
  // ch_sel is one-hot, so masking ready/rdata with it picks the selected channel and ignores the rest
  assign hit = |(ch_sel & ch_ready);
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < N_CH; k++) sel_rdata |= ch_sel[k] ? ch_rdata[k*DATA_W +: DATA_W] : '0;
  end
`ifdef MMIO_TIMEOUT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (state == ACCESS && !hit) ? cnt + 16'd1 : '0;
  assign expired = state == ACCESS && !hit && cnt == 16'(TIMEOUT_CYC - 1);
`else
  assign expired = TIMEOUT_CYC < 0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err <= 1'b0;
      ch_sel <= '0;
      ch_we <= 1'b0;
      ch_off <= '0;
      ch_be <= '0;
      ch_wdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_err <= 1'b0;
      cpu_rdata <= '0;
      case (state)
        IDLE: if (cpu_req) begin
          if (in_range) begin
            ch_sel <= N_CH'(1) << idx;
            ch_we <= cpu_we;
            ch_off <= off;
            ch_be <= cpu_be;
            ch_wdata <= cpu_wdata;
            state <= ACCESS;
          end else begin
            cpu_ready <= 1'b1;
            cpu_err <= 1'b1;
            state <= RESP;
          end
        end
        ACCESS: if (hit || expired) begin
          ch_sel <= '0;
          ch_we <= 1'b0;
          cpu_ready <= 1'b1;
          cpu_err <= !hit;
          cpu_rdata <= !hit ? DATA_W'(TIMEOUT_DATA) : ch_we ? '0 : sel_rdata;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed self-checking bench for mmio_bridge
module tb_mmio_bridge;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata;
  logic [3:0] cpu_be = '0, ch_sel, ch_be, ch_ready = 4'hF;
  logic cpu_ready, cpu_err, ch_we;
  logic [1:0] ch_off;
  logic [31:0] ch_wdata;
  logic [127:0] ch_rdata = {32'h3333_0003, 32'h0000_1234, 32'h2222_0001, 32'h1111_0000};
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mmio_bridge #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_be(cpu_be), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cpu_err(cpu_err), .ch_sel(ch_sel), .ch_we(ch_we), .ch_off(ch_off), .ch_be(ch_be),
    .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_ready(ch_ready)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = addr;
    cpu_be = 4'hF;
    cpu_wdata = wd;
  endtask
  task automatic test_reset;
    #3;
    tests++;
    if ({cpu_ready, cpu_err, ch_we, ch_sel, ch_off, ch_be} !== 13'd0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 0", {cpu_ready, cpu_err, ch_we, ch_sel, ch_off, ch_be});
    end
    tests++;
    if (cpu_rdata !== 32'd0 || ch_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_data: rdata=%h wdata=%h expected 0", cpu_rdata, ch_wdata);
    end
    step();
    rst = 1'b1;
    step();
  endtask
  task automatic test_zero_wait_store;
    ch_ready = 4'hF;
    req(1'b1, 32'hFFFF_FC00, 32'h0000_00A5);
    step();
    tests++;
    if (ch_sel !== 4'b0001 || ch_we !== 1'b1 || ch_wdata !== 32'hA5 || cpu_ready !== 1'b0) begin
      fails++;
      $display("FAIL store_strobe: sel=%b we=%b wdata=%h ready=%b expected 0001 1 a5 0", ch_sel, ch_we, ch_wdata, cpu_ready);
    end
    step();
    tests++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'd0 || ch_sel !== 4'd0 || ch_we !== 1'b0) begin
      fails++;
      $display("FAIL store_resp: ready=%b err=%b rdata=%h sel=%b we=%b expected 1 0 0 0000 0", cpu_ready, cpu_err, cpu_rdata, ch_sel, ch_we);
    end
    cpu_req = 1'b0;
    step();
    tests++;
    if (cpu_ready !== 1'b0) begin
      fails++;
      $display("FAIL store_pulse: ready=%b expected 0", cpu_ready);
    end
  endtask
  task automatic test_wait_load;
    logic early = 1'b0;
    ch_ready = 4'b1011;
    req(1'b0, 32'hFFFF_FC24, 32'h0);
    step();
    tests++;
    if (ch_sel !== 4'b0100 || ch_off !== 2'd1 || ch_we !== 1'b0) begin
      fails++;
      $display("FAIL wait_strobe: sel=%b off=%0d we=%b expected 0100 1 0", ch_sel, ch_off, ch_we);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      early |= cpu_ready;
    end
    tests++;
    if (early !== 1'b0 || ch_sel !== 4'b0100) begin
      fails++;
      $display("FAIL wait_hold: early_ready=%b sel=%b expected 0 0100", early, ch_sel);
    end
    ch_ready = 4'hF;
    step();
    tests++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h0000_1234) begin
      fails++;
      $display("FAIL wait_resp: ready=%b err=%b rdata=%h expected 1 0 00001234", cpu_ready, cpu_err, cpu_rdata);
    end
    cpu_req = 1'b0;
    step();
  endtask
  task automatic test_out_of_range;
    req(1'b0, 32'hFFFF_FC40, 32'h0);
    step();
    tests++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'd0 || ch_sel !== 4'd0) begin
      fails++;
      $display("FAIL oor_high: ready=%b err=%b rdata=%h sel=%b expected 1 1 0 0000", cpu_ready, cpu_err, cpu_rdata, ch_sel);
    end
    cpu_addr = 32'hFFFF_FBFC;
    step();
    step();
    tests++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b1 || ch_sel !== 4'd0) begin
      fails++;
      $display("FAIL oor_low: ready=%b err=%b sel=%b expected 1 1 0000", cpu_ready, cpu_err, ch_sel);
    end
    cpu_req = 1'b0;
    step();
  endtask
  task automatic test_back_to_back;
    ch_ready = 4'hF;
    req(1'b0, 32'hFFFF_FC00, 32'h0);
    step();
    tests++;
    if (ch_sel !== 4'b0001) begin
      fails++;
      $display("FAIL b2b_sel0: sel=%b expected 0001", ch_sel);
    end
    step();
    tests++;
    if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h1111_0000) begin
      fails++;
      $display("FAIL b2b_data0: ready=%b rdata=%h expected 1 11110000", cpu_ready, cpu_rdata);
    end
    cpu_addr = 32'hFFFF_FC3C;
    step();
    tests++;
    if (cpu_ready !== 1'b0 || ch_sel !== 4'd0) begin
      fails++;
      $display("FAIL b2b_gap: ready=%b sel=%b expected 0 0000", cpu_ready, ch_sel);
    end
    step();
    tests++;
    if (ch_sel !== 4'b1000 || ch_off !== 2'd3) begin
      fails++;
      $display("FAIL b2b_sel3: sel=%b off=%0d expected 1000 3", ch_sel, ch_off);
    end
    step();
    tests++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h3333_0003) begin
      fails++;
      $display("FAIL b2b_data3: ready=%b err=%b rdata=%h expected 1 0 33330003", cpu_ready, cpu_err, cpu_rdata);
    end
    cpu_req = 1'b0;
    step();
  endtask
  task automatic test_reset_mid;
    ch_ready = 4'b1101;
    req(1'b1, 32'hFFFF_FC14, 32'h5A5A_5A5A);
    step();
    step();
    tests++;
    if (ch_sel !== 4'b0010 || ch_we !== 1'b1) begin
      fails++;
      $display("FAIL rmid_busy: sel=%b we=%b expected 0010 1", ch_sel, ch_we);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (ch_sel !== 4'd0 || ch_we !== 1'b0 || cpu_ready !== 1'b0) begin
      fails++;
      $display("FAIL rmid_async: sel=%b we=%b ready=%b expected 0000 0 0", ch_sel, ch_we, cpu_ready);
    end
    cpu_req = 1'b0;
    step();
    rst = 1'b1;
    ch_ready = 4'hF;
    step();
    req(1'b0, 32'hFFFF_FC10, 32'h0);
    step();
    step();
    tests++;
    if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h2222_0001) begin
      fails++;
      $display("FAIL rmid_after: ready=%b err=%b rdata=%h expected 1 0 22220001", cpu_ready, cpu_err, cpu_rdata);
    end
    cpu_req = 1'b0;
    step();
  endtask
  task automatic test_timeout;
    int cyc = 0;
    ch_ready = 4'b1110;
    req(1'b0, 32'hFFFF_FC00, 32'h0);
`ifdef MMIO_TIMEOUT_EN
    while (cpu_ready !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
    tests++;
    if (cyc != 9 || cpu_err !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF || ch_sel !== 4'd0) begin
      fails++;
      $display("FAIL timeout: cycles=%0d err=%b rdata=%h sel=%b expected 9 1 deadbeef 0000", cyc, cpu_err, cpu_rdata, ch_sel);
    end
    cpu_req = 1'b0;
    step();
`else
    for (int i = 0; i < 100; i++) begin
      step();
      cyc += int'(cpu_ready);
    end
    tests++;
    if (cyc != 0 || ch_sel !== 4'b0001) begin
      fails++;
      $display("FAIL no_timeout: ready_pulses=%0d sel=%b expected 0 0001", cyc, ch_sel);
    end
    cpu_req = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
`endif
    ch_ready = 4'hF;
  endtask
  initial begin
    test_reset();
    test_zero_wait_store();
    test_wait_load();
    test_out_of_range();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
